cpu_bus_arbiter: RTL and testbench

Shares the single external memory port between the CPU instruction-fetch unit and the execute-stage data port (load/store). It accepts one-cycle request pulses from each side, holds them until granted, and runs one memory transaction at a time. It returns read data and a one-cycle acknowledge to the originating requester. Data requests have priority, with a bounded-streak guard so instruction fetch cannot starve.

---
 rtl/cpu_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the single memory port between the execute-stage data port and instruction fetch.
// Data wins by default; a bounded data streak guarantees a waiting fetch eventually gets the port.
module cpu_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_request,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_overrun,
  input  logic        i_request,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        mem_request,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_D = 2'd1, BUSY_I = 2'd2} state_t;

  localparam logic [1:0] MAX_STREAK = 2'(MAX_DATA_STREAK);

  // Handshake: request inputs are single-cycle pulses captured into holding registers;
  // mem_request pulses once per transaction and the mem_* fields stay valid until mem_ack;
  // d_ack/i_ack pulse once, one cycle after mem_ack, with their rdata.
  state_t      state_q, state_d;
  logic [1:0]  streak_q, streak_d;
  logic        kill_q, kill_d;
  logic        pend_d_v_q, pend_d_v_d;
  logic [31:0] pend_d_addr_q, pend_d_addr_d;
  logic        pend_d_write_q, pend_d_write_d;
  logic [3:0]  pend_d_be_q, pend_d_be_d;
  logic [31:0] pend_d_wdata_q, pend_d_wdata_d;
  logic [1:0]  pend_d_size_q, pend_d_size_d;
  logic        pend_i_v_q, pend_i_v_d;
  logic [31:0] pend_i_addr_q, pend_i_addr_d;
  logic        mem_request_q, mem_request_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_overrun_q, d_overrun_d;
  logic        i_ack_q, i_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;

  logic decide, d_ovr, d_take, d_cand, i_cand, grant_d, grant_i, i_killed;

  always_comb begin
    // A data transaction whose mem_ack is arriving now no longer blocks a new data request.
    d_ovr    = d_request && (pend_d_v_q || (state_q == BUSY_D && !mem_ack));
    d_take   = d_request && !d_ovr;
    d_cand   = pend_d_v_q || d_take;
    i_cand   = (pend_i_v_q && !i_flush) || i_request;
    decide   = (state_q == IDLE) || mem_ack;
    grant_d  = decide && d_cand && (!i_cand || streak_q < MAX_STREAK);
    grant_i  = decide && !grant_d && i_cand;
    i_killed = kill_q || i_flush || i_request;

    state_d        = state_q;
    streak_d       = streak_q;
    kill_d         = 1'b0;
    pend_d_v_d     = pend_d_v_q;
    pend_d_addr_d  = pend_d_addr_q;
    pend_d_write_d = pend_d_write_q;
    pend_d_be_d    = pend_d_be_q;
    pend_d_wdata_d = pend_d_wdata_q;
    pend_d_size_d  = pend_d_size_q;
    pend_i_v_d     = (pend_i_v_q && !i_flush) || i_request;
    pend_i_addr_d  = i_request ? i_addr : pend_i_addr_q;
    mem_request_d  = grant_d || grant_i;
    mem_addr_d     = mem_addr_q;
    mem_write_d    = mem_write_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    mem_size_d     = mem_size_q;
    d_ack_d        = (state_q == BUSY_D) && mem_ack;
    d_rdata_d      = d_rdata_q;
    d_overrun_d    = d_ovr;
    i_ack_d        = (state_q == BUSY_I) && mem_ack && !i_killed;
    i_rdata_d      = i_rdata_q;

    if (d_take) begin
      pend_d_v_d     = 1'b1;
      pend_d_addr_d  = d_addr;
      pend_d_write_d = d_write;
      pend_d_be_d    = d_byte_enable;
      pend_d_wdata_d = d_wdata;
      pend_d_size_d  = d_size;
    end

    if (state_q == BUSY_I && !mem_ack) kill_d = i_killed;
    if (d_ack_d) d_rdata_d = mem_rdata;
    if (i_ack_d) i_rdata_d = mem_rdata;

    // Fields come from the holding register if valid, otherwise straight from the pulse.
    if (grant_d) begin
      state_d     = BUSY_D;
      pend_d_v_d  = 1'b0;
      mem_addr_d  = pend_d_v_q ? pend_d_addr_q  : d_addr;
      mem_write_d = pend_d_v_q ? pend_d_write_q : d_write;
      mem_be_d    = pend_d_v_q ? pend_d_be_q    : d_byte_enable;
      mem_wdata_d = pend_d_v_q ? pend_d_wdata_q : d_wdata;
      mem_size_d  = pend_d_v_q ? pend_d_size_q  : d_size;
    end else if (grant_i) begin
      state_d     = BUSY_I;
      pend_i_v_d  = 1'b0;
      mem_addr_d  = i_request ? i_addr : pend_i_addr_q;
      mem_write_d = 1'b0;
      mem_be_d    = 4'b1111;
      mem_wdata_d = 32'd0;
      mem_size_d  = 2'b10;
    end else if (decide) begin
      state_d     = IDLE;
      mem_addr_d  = 32'd0;
      mem_write_d = 1'b0;
      mem_be_d    = 4'd0;
      mem_wdata_d = 32'd0;
      mem_size_d  = 2'd0;
    end

    if (!i_cand || grant_i) streak_d = 2'd0;
    else if (grant_d && streak_q != 2'b11) streak_d = streak_q + 2'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      streak_q       <= 2'd0;
      kill_q         <= 1'b0;
      pend_d_v_q     <= 1'b0;
      pend_d_addr_q  <= 32'd0;
      pend_d_write_q <= 1'b0;
      pend_d_be_q    <= 4'd0;
      pend_d_wdata_q <= 32'd0;
      pend_d_size_q  <= 2'd0;
      pend_i_v_q     <= 1'b0;
      pend_i_addr_q  <= 32'd0;
      mem_request_q  <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_write_q    <= 1'b0;
      mem_be_q       <= 4'd0;
      mem_wdata_q    <= 32'd0;
      mem_size_q     <= 2'd0;
      d_ack_q        <= 1'b0;
      d_rdata_q      <= 32'd0;
      d_overrun_q    <= 1'b0;
      i_ack_q        <= 1'b0;
      i_rdata_q      <= 32'd0;
    end else begin
      state_q        <= state_d;
      streak_q       <= streak_d;
      kill_q         <= kill_d;
      pend_d_v_q     <= pend_d_v_d;
      pend_d_addr_q  <= pend_d_addr_d;
      pend_d_write_q <= pend_d_write_d;
      pend_d_be_q    <= pend_d_be_d;
      pend_d_wdata_q <= pend_d_wdata_d;
      pend_d_size_q  <= pend_d_size_d;
      pend_i_v_q     <= pend_i_v_d;
      pend_i_addr_q  <= pend_i_addr_d;
      mem_request_q  <= mem_request_d;
      mem_addr_q     <= mem_addr_d;
      mem_write_q    <= mem_write_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_size_q     <= mem_size_d;
      d_ack_q        <= d_ack_d;
      d_rdata_q      <= d_rdata_d;
      d_overrun_q    <= d_overrun_d;
      i_ack_q        <= i_ack_d;
      i_rdata_q      <= i_rdata_d;
    end
  end

  assign d_ack           = d_ack_q;
  assign d_rdata         = d_rdata_q;
  assign d_overrun       = d_overrun_q;
  assign i_ack           = i_ack_q;
  assign i_rdata         = i_rdata_q;
  assign mem_request     = mem_request_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_size        = mem_size_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: every scenario drives a hand-timed cycle script
// and compares outputs #1 after the rising edge against hand-computed values.
module tb_cpu_bus_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY_D = 2'd1, S_BUSY_I = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        d_request = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_write = 1'b0;
  logic [3:0]  d_byte_enable = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = 2'b10;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_overrun;
  logic        i_request = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  cpu_bus_arbiter #(.MAX_DATA_STREAK(3)) dut (
    .clock(clock), .reset(reset),
    .d_request(d_request), .d_addr(d_addr), .d_write(d_write),
    .d_byte_enable(d_byte_enable), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_overrun(d_overrun),
    .i_request(i_request), .i_addr(i_addr), .i_flush(i_flush),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One cycle of stimulus: pulses are applied for a single edge, then dropped.
  task automatic drive_cycle(input logic dreq, input logic [31:0] daddr,
                             input logic ireq, input logic [31:0] iaddr,
                             input logic flush, input logic mack,
                             input logic [31:0] mrdata);
    d_request = dreq;
    d_addr    = daddr;
    i_request = ireq;
    i_addr    = iaddr;
    i_flush   = flush;
    mem_ack   = mack;
    mem_rdata = mrdata;
    step();
    d_request = 1'b0;
    i_request = 1'b0;
    i_flush   = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata, mem_size} !== 72'd0) begin
      errors++;
      $display("FAIL reset_mem: got req=%b addr=%h be=%h size=%h expected all zero",
               mem_request, mem_addr, mem_byte_enable, mem_size);
    end
    checks++;
    if ({d_ack, d_rdata, d_overrun, i_ack, i_rdata, dbg_state} !== 69'd0) begin
      errors++;
      $display("FAIL reset_out: got d_ack=%b d_rdata=%h ovr=%b i_ack=%b i_rdata=%h st=%0d expected zero",
               d_ack, d_rdata, d_overrun, i_ack, i_rdata, dbg_state);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_idle_read();
    drive_cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({mem_request, mem_addr, mem_write, dbg_state} !== {1'b1, 32'h100, 1'b0, S_BUSY_D}) begin
      errors++;
      $display("FAIL idle_read_issue: got req=%b addr=%h wr=%b st=%0d expected 1 100 0 1",
               mem_request, mem_addr, mem_write, dbg_state);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({mem_request, mem_addr} !== {1'b0, 32'h100}) begin
      errors++;
      $display("FAIL idle_read_hold: got req=%b addr=%h expected 0 100", mem_request, mem_addr);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (d_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_read_early_ack: got d_ack=%b expected 0", d_ack);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    checks++;
    if ({d_ack, d_rdata, i_ack, mem_addr, dbg_state} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0, S_IDLE}) begin
      errors++;
      $display("FAIL idle_read_ack: got d_ack=%b rdata=%h i_ack=%b addr=%h st=%0d expected 1 deadbeef 0 0 0",
               d_ack, d_rdata, i_ack, mem_addr, dbg_state);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({d_ack, d_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL idle_read_hold_rdata: got d_ack=%b rdata=%h expected 0 deadbeef", d_ack, d_rdata);
    end
  endtask

  task automatic test_simultaneous();
    d_write = 1'b1;
    d_byte_enable = 4'b0011;
    d_wdata = 32'h0000BEEF;
    d_size = 2'b01;
    drive_cycle(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    d_write = 1'b0;
    d_byte_enable = 4'b0000;
    d_wdata = 32'h0;
    d_size = 2'b10;
    checks++;
    if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata, mem_size}
        !== {1'b1, 32'h200, 1'b1, 4'b0011, 32'h0000BEEF, 2'b01}) begin
      errors++;
      $display("FAIL simul_data_first: got req=%b addr=%h wr=%b be=%b wdata=%h size=%b expected 1 200 1 0011 0000beef 01",
               mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata, mem_size);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    checks++;
    if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_size, d_ack, dbg_state}
        !== {1'b1, 32'h300, 1'b0, 4'b1111, 2'b10, 1'b1, S_BUSY_I}) begin
      errors++;
      $display("FAIL simul_fetch_b2b: got req=%b addr=%h wr=%b be=%b size=%b d_ack=%b st=%0d expected 1 300 0 1111 10 1 2",
               mem_request, mem_addr, mem_write, mem_byte_enable, mem_size, d_ack, dbg_state);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    checks++;
    if ({i_ack, i_rdata, d_ack, mem_request, dbg_state} !== {1'b1, 32'hCAFEF00D, 1'b0, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL simul_fetch_ack: got i_ack=%b i_rdata=%h d_ack=%b req=%b st=%0d expected 1 cafef00d 0 0 0",
               i_ack, i_rdata, d_ack, mem_request, dbg_state);
    end
    step();
  endtask

  task automatic test_streak();
    logic [31:0] daddr;
    drive_cycle(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      daddr = 32'h1000 + 32'(4 * k);
      checks++;
      if ({mem_request, mem_addr, dbg_state} !== {1'b1, daddr, S_BUSY_D}) begin
        errors++;
        $display("FAIL streak_data_grant%0d: got req=%b addr=%h st=%0d expected 1 %h 1",
                 k, mem_request, mem_addr, dbg_state, daddr);
      end
      drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, daddr + 32'd4, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0 + 32'(k));
      checks++;
      if ({d_ack, d_rdata} !== {1'b1, 32'hA0 + 32'(k)}) begin
        errors++;
        $display("FAIL streak_d_ack%0d: got d_ack=%b rdata=%h expected 1 %h", k, d_ack, d_rdata, 32'hA0 + 32'(k));
      end
    end
    checks++;
    if ({mem_request, mem_addr, dbg_state} !== {1'b1, 32'h2000, S_BUSY_I}) begin
      errors++;
      $display("FAIL streak_fetch_grant: got req=%b addr=%h st=%0d expected 1 2000 2", mem_request, mem_addr, dbg_state);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0F0F0F0F);
    checks++;
    if ({mem_request, mem_addr, dbg_state, i_ack, i_rdata} !== {1'b1, 32'h100C, S_BUSY_D, 1'b1, 32'h0F0F0F0F}) begin
      errors++;
      $display("FAIL streak_data_resume: got req=%b addr=%h st=%0d i_ack=%b i_rdata=%h expected 1 100c 1 1 0f0f0f0f",
               mem_request, mem_addr, dbg_state, i_ack, i_rdata);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA3);
    checks++;
    if ({d_ack, d_rdata, dbg_state} !== {1'b1, 32'hA3, S_IDLE}) begin
      errors++;
      $display("FAIL streak_last_ack: got d_ack=%b rdata=%h st=%0d expected 1 a3 0", d_ack, d_rdata, dbg_state);
    end
    step();
  endtask

  task automatic test_flush();
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({mem_request, mem_addr, dbg_state} !== {1'b1, 32'h400, S_BUSY_I}) begin
      errors++;
      $display("FAIL flush_first_fetch: got req=%b addr=%h st=%0d expected 1 400 2", mem_request, mem_addr, dbg_state);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({mem_request, i_ack} !== 2'b00) begin
      errors++;
      $display("FAIL flush_no_issue: got req=%b i_ack=%b expected 0 0", mem_request, i_ack);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111);
    checks++;
    if ({i_ack, i_rdata, mem_request, mem_addr} !== {1'b0, 32'h0F0F0F0F, 1'b1, 32'h500}) begin
      errors++;
      $display("FAIL flush_killed_ack: got i_ack=%b i_rdata=%h req=%b addr=%h expected 0 0f0f0f0f 1 500",
               i_ack, i_rdata, mem_request, mem_addr);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222);
    checks++;
    if ({i_ack, i_rdata, dbg_state} !== {1'b1, 32'h2222, S_IDLE}) begin
      errors++;
      $display("FAIL flush_new_fetch_ack: got i_ack=%b i_rdata=%h st=%0d expected 1 2222 0", i_ack, i_rdata, dbg_state);
    end
    step();
  endtask

  task automatic test_overrun();
    drive_cycle(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({mem_request, mem_addr, d_overrun} !== {1'b1, 32'h600, 1'b0}) begin
      errors++;
      $display("FAIL overrun_first: got req=%b addr=%h ovr=%b expected 1 600 0", mem_request, mem_addr, d_overrun);
    end
    drive_cycle(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({d_overrun, mem_request, mem_addr} !== {1'b1, 1'b0, 32'h600}) begin
      errors++;
      $display("FAIL overrun_pulse: got ovr=%b req=%b addr=%h expected 1 0 600", d_overrun, mem_request, mem_addr);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6666);
    checks++;
    if ({d_ack, d_rdata, d_overrun, mem_request, dbg_state} !== {1'b1, 32'h6666, 1'b0, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL overrun_dropped: got d_ack=%b rdata=%h ovr=%b req=%b st=%0d expected 1 6666 0 0 0",
               d_ack, d_rdata, d_overrun, mem_request, dbg_state);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (mem_request !== 1'b0) begin
      errors++;
      $display("FAIL overrun_no_second: got req=%b expected 0", mem_request);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_request, mem_addr, d_rdata, dbg_state} !== {1'b0, 32'h0, 32'h0, S_IDLE}) begin
      errors++;
      $display("FAIL reset_mid_clear: got req=%b addr=%h d_rdata=%h st=%0d expected 0 0 0 0",
               mem_request, mem_addr, d_rdata, dbg_state);
    end
    step();
    reset = 1'b0;
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777);
    checks++;
    if ({d_ack, d_rdata, mem_request, dbg_state} !== {1'b0, 32'h0, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL reset_late_ack: got d_ack=%b rdata=%h req=%b st=%0d expected 0 0 0 0",
               d_ack, d_rdata, mem_request, dbg_state);
    end
    drive_cycle(1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({mem_request, mem_addr} !== {1'b1, 32'h900}) begin
      errors++;
      $display("FAIL reset_after_issue: got req=%b addr=%h expected 1 900", mem_request, mem_addr);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555);
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, 32'h5555}) begin
      errors++;
      $display("FAIL reset_after_ack: got d_ack=%b rdata=%h expected 1 5555", d_ack, d_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_simultaneous();
    test_streak();
    test_flush();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
